// File: rtl/johnson_seq_ctrl.sv
// Sequencing controller for the Johnson counter datapath.
// Runs the shift register for a programmed number of revolutions.
module johnson_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           pause,
  input  logic [CW-1:0]                  cycles,
  output logic [WIDTH-1:0]               jc_out,
  output logic [$clog2(2*WIDTH)-1:0]     phase,
  output logic                           busy,
  output logic                           wrap,
  output logic                           done,
  output logic                           err
);

  localparam int STEPS = 2 * WIDTH;
  localparam int PW    = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [WIDTH-1:0] jc_q, jc_d;
  logic [PW-1:0]  ph_q, ph_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic           wrap_q, wrap_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           last;

  assign last = (ph_q == PW'(STEPS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      jc_q    <= '0;
      ph_q    <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      jc_q    <= jc_d;
      ph_q    <= ph_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    jc_d    = jc_q;
    ph_d    = ph_q;
    rem_d   = rem_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!stop && start) begin
          if (cycles == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = RUN;
            jc_d    = '0;
            ph_d    = '0;
            rem_d   = cycles;
          end
        end
      end
      RUN, PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          jc_d    = '0;
          ph_d    = '0;
          rem_d   = '0;
        end else begin
          err_d = start;
          if (pause) begin
            state_d = PAUSE;
          end else begin
            // Leaving PAUSE advances on the same edge pause is seen low.
            state_d = RUN;
            jc_d    = {jc_q[WIDTH-2:0], ~jc_q[WIDTH-1]};
            ph_d    = last ? '0 : ph_q + PW'(1);
            if (last) begin
              wrap_d = 1'b1;
              rem_d  = rem_q - CW'(1);
              if (rem_q == CW'(1)) begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign jc_out = jc_q;
  assign phase  = ph_q;
  assign busy   = (state_q == RUN) || (state_q == PAUSE);
  assign wrap   = wrap_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: directed scenarios plus random
// traffic against a revolution-level reference model.
module tb_johnson_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] cycles = 8'd0;
  logic [7:0] jc_out;
  logic [3:0] phase;
  logic       busy, wrap, done, err;

  int total = 0;
  int bad = 0;

  int m_ph, m_rem;
  bit m_act, m_indone, m_wrap, m_done, m_err;

  johnson_seq_ctrl #(.WIDTH(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pause(pause), .cycles(cycles), .jc_out(jc_out),
    .phase(phase), .busy(busy), .wrap(wrap), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] jc_of(int p);
    int v;
    if (p <= 8) v = (1 << p) - 1;
    else v = (255 << (p - 8)) & 255;
    return v[7:0];
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [3:0] p4;
    p4 = m_ph[3:0];
    return {jc_of(m_ph), p4, m_act, m_wrap, m_done, m_err};
  endfunction

  function automatic logic [15:0] got_vec();
    return {jc_out, phase, busy, wrap, done, err};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_rem = 0; m_act = 0; m_indone = 0;
    m_wrap = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit s, st, pa, input int c);
    m_wrap = 0; m_done = 0; m_err = 0;
    if (m_indone) begin
      m_indone = 0;
    end else if (!m_act) begin
      if (!st && s) begin
        if (c == 0) m_err = 1;
        else begin m_act = 1; m_rem = c; m_ph = 0; end
      end
    end else if (st) begin
      m_act = 0; m_ph = 0; m_rem = 0;
    end else begin
      m_err = s;
      if (!pa) begin
        m_ph = (m_ph + 1) % 16;
        if (m_ph == 0) begin
          m_wrap = 1;
          m_rem = m_rem - 1;
          if (m_rem == 0) begin m_act = 0; m_done = 1; m_indone = 1; end
        end
      end
    end
  endtask

  task automatic step(input logic s, st, pa, input logic [7:0] c);
    start = s; stop = st; pause = pa; cycles = c;
    @(posedge clk);
    model_edge(s, st, pa, int'(c));
    #1;
  endtask

  task automatic drain();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b0;
    #3;
    if (got_vec() !== 16'h0000) begin
      bad++; $display("FAIL reset got=%h exp=0000", got_vec());
    end
    total++;
    rst = 1'b1;
  endtask

  task automatic test_single();
    step(1, 0, 0, 8'd1);
    for (int i = 1; i <= 17; i++) begin
      step(0, 0, 0, 8'd0);
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL single c%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      total++;
    end
  endtask

  task automatic test_multi();
    int wraps = 0;
    step(1, 0, 0, 8'd3);
    for (int i = 1; i <= 50; i++) begin
      step(0, 0, 0, 8'd0);
      if (wrap === 1'b1) wraps++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL multi c%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      total++;
    end
    if (wraps != 3) begin
      bad++; $display("FAIL multi_wraps got=%0d exp=3", wraps);
    end
    total++;
  endtask

  task automatic test_pause();
    int n = 0;
    step(1, 0, 0, 8'd2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 8'd0);
      n++;
      if (jc_out !== 8'h07 || phase !== 4'd3 || wrap !== 1'b0) begin
        bad++;
        $display("FAIL pause_hold jc=%h ph=%0d exp jc=07 ph=3", jc_out, phase);
      end
      total++;
    end
    n = n + 3;
    while (done !== 1'b1 && n < 100) begin
      step(0, 0, 0, 8'd0);
      n++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL pause_run c%0d got=%h exp=%h", n, got_vec(), exp_vec());
      end
      total++;
    end
    if (n != 37) begin
      bad++; $display("FAIL pause_len got=%0d exp=37", n);
    end
    total++;
  endtask

  task automatic test_stop();
    step(0, 0, 0, 8'd0);
    step(1, 0, 0, 8'd4);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 8'd0);
    if (jc_out !== 8'hFE) begin
      bad++; $display("FAIL stop_pre jc=%h exp=fe", jc_out);
    end
    total++;
    step(0, 1, 0, 8'd0);
    if (got_vec() !== 16'h0000) begin
      bad++; $display("FAIL stop got=%h exp=0000", got_vec());
    end
    total++;
    step(1, 0, 0, 8'd1);
    for (int i = 1; i <= 17; i++) begin
      step(0, 0, 0, 8'd0);
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL restart c%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      total++;
    end
  endtask

  task automatic test_err();
    step(1, 0, 0, 8'd0);
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL err_zero err=%b busy=%b exp 1/0", err, busy);
    end
    total++;
    step(1, 0, 0, 8'd2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'd0);
    step(1, 0, 0, 8'd7);
    if (got_vec() !== exp_vec() || err !== 1'b1) begin
      bad++; $display("FAIL err_busy got=%h exp=%h", got_vec(), exp_vec());
    end
    total++;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 8'd0);
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL err_run c%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      total++;
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 8'd0);
    step(1, 0, 0, 8'd2);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 8'd0);
    if (jc_out !== 8'h3F) begin
      bad++; $display("FAIL areset_pre jc=%h exp=3f", jc_out);
    end
    total++;
    #2 rst = 1'b0;
    #1;
    model_reset();
    if (got_vec() !== 16'h0000) begin
      bad++; $display("FAIL areset got=%h exp=0000", got_vec());
    end
    total++;
    #1 rst = 1'b1;
    step(0, 0, 0, 8'd0);
    if (got_vec() !== 16'h0000) begin
      bad++; $display("FAIL areset_rel got=%h exp=0000", got_vec());
    end
    total++;
  endtask

  task automatic test_stop_on_complete();
    step(1, 0, 0, 8'd1);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 8'd0);
    step(0, 1, 1, 8'd0);
    if (got_vec() !== 16'h0000) begin
      bad++; $display("FAIL stop_complete got=%h exp=0000", got_vec());
    end
    total++;
    step(0, 0, 0, 8'd0);
    if (done !== 1'b0 || wrap !== 1'b0) begin
      bad++; $display("FAIL stop_complete_after done=%b wrap=%b exp 0", done, wrap);
    end
    total++;
  endtask

  task automatic test_random();
    logic s, st, pa;
    logic [7:0] c;
    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 59) == 0);
      pa = ($urandom_range(0, 7) == 0);
      c  = 8'($urandom_range(0, 3));
      step(s, st, pa, c);
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random c%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    drain();
    test_multi();
    drain();
    test_pause();
    drain();
    test_stop();
    drain();
    test_err();
    drain();
    test_async_reset();
    drain();
    test_stop_on_complete();
    drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
Sequencing controller for the 8-bit Johnson counter datapath. It owns the shift register and runs it for a programmed number of full revolutions (2*WIDTH states each). It supports pause and abort, and reports phase index, wrap and completion to downstream phase-decode logic. It sits between the control/CSR side (start/stop/pause/cycles) and the consumers of the Johnson pattern.

Parameters:
WIDTH, 8, Johnson register width; one revolution = 2*WIDTH states (16 by default)
CW, 8, width of the revolution-count input and the internal remaining-revolutions counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request a run; sampled in IDLE only
stop  input  1  abort the run; highest priority
pause  input  1  level; hold the pattern while high
cycles  input  CW  number of full revolutions to run; sampled with start
jc_out  output  WIDTH  registered Johnson pattern
phase  output  $clog2(2*WIDTH)  registered state index 0..2*WIDTH-1 matching jc_out
busy  output  1  high in RUN or PAUSE
wrap  output  1  one-cycle pulse when jc_out returns to all-zeros during a run
done  output  1  one-cycle pulse when the programmed revolutions complete
err  output  1  one-cycle pulse on a rejected start

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, jc_out=0, phase=0, remaining=0, busy=wrap=done=err=0.
- Johnson step: jc_next = {jc_out[WIDTH-2:0], ~jc_out[WIDTH-1]}.
  - Sequence: 0x00, 0x01, 0x03, ..., 0xFF, 0xFE, 0xFC, ..., 0x80, 0x00.
  - phase increments by 1 per step and wraps from 2*WIDTH-1 to 0.
- FSM states: IDLE, RUN, PAUSE, DONE.
- Input priority: stop > pause > start.
- IDLE:
  - start=1 and cycles!=0: next state RUN; jc_out=0, phase=0, remaining=cycles; busy=1 from that edge.
  - start=1 and cycles==0: err=1 for one cycle; stay IDLE.
  - jc_out stays at 0.
- RUN, advance edge: jc_out and phase advance one step per clock.
  - First advance is on the edge after start is accepted, so jc_out=0x01 one cycle after busy rises.
- RUN, return to 0x00 (step 0x80 -> 0x00, i.e. phase 2*WIDTH-1 -> 0):
  - wrap=1 in the cycle where jc_out==0; remaining decrements.
  - If remaining was 1: next state DONE, done=1 and busy=0 in that same cycle, jc_out holds 0x00.
  - Otherwise stay in RUN and continue.
- Run length: a run of N revolutions takes exactly N*2*WIDTH clocks from the start-accept edge to the done pulse.
- RUN with pause=1 (stop=0): next state PAUSE; jc_out, phase and remaining frozen (no advance on that edge).
- PAUSE:
  - Holds all state while pause=1; busy stays 1.
  - pause=0: return to RUN and resume advancing on the following edge.
  - No wrap is generated in PAUSE.
- stop=1 in RUN or PAUSE: next state IDLE; jc_out=0, phase=0, remaining=0, busy=0; no done, no wrap.
- DONE: lasts one cycle (done=1), then IDLE unconditionally. A start in DONE is ignored with no err.
- start in RUN or PAUSE: ignored, err=1 for one cycle.
- stop in IDLE or DONE: no effect.
- Simultaneous events:
  - stop with a completing wrap edge: stop wins; no done, no wrap.
  - pause on the completing edge: pause wins; the edge is frozen and completion occurs after resume.
- Reset asserted mid-run: immediate return to reset values; no done pulse on release.
- Outputs wrap, done and err are registered single-cycle pulses; none ever lasts more than one cycle.

Test Plan:
1. Reset, then start=1 with cycles=1 for one clock -> busy=1; jc_out steps 0x01, 0x03, ..., 0xFF, 0xFE, ..., 0x80, 0x00; wrap=done=1 exactly 16 clocks after start accepted; busy=0; IDLE next cycle.
2. cycles=3 -> three wrap pulses at clocks 16, 32 and 48 after accept; done only with the third; phase cycles 0..15 three times.
3. cycles=2, pause=1 for 5 clocks while jc_out=0x07 -> jc_out and phase (3) held for 5 cycles, no wrap; done at 16*2+5 = 37 clocks after accept.
4. cycles=4, stop=1 when phase=9 (jc_out=0xFE) -> next edge jc_out=0x00, phase=0, busy=0; no done/wrap pulses; a new start with cycles=1 runs normally.
5. start with cycles=0 -> err pulse, busy stays 0. start while busy -> err pulse, run unaffected.
6. rst driven low asynchronously mid-clock while jc_out=0x3F -> jc_out=0, busy=0 immediately without a clock edge. stop and pause asserted together on the completing edge -> stop wins, no done pulse.
